// File: rtl/hsv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hsv_pkg
// Purpose  : Shared HSV constants, widths and hue-sector codes.
// Revision : 1.0 - initial release
// ============================================================================
package hsv_pkg;

    localparam int H_W           = 9;
    localparam int SV_W          = 6;
    localparam int HUE_WRAP      = 360;
    localparam int HUE_SECTOR    = 60;
    localparam int RECIP60       = 2185;
    localparam int RECIP60_SHIFT = 17;

    typedef enum logic [2:0] {
        SEC_0 = 3'd0,
        SEC_1 = 3'd1,
        SEC_2 = 3'd2,
        SEC_3 = 3'd3,
        SEC_4 = 3'd4,
        SEC_5 = 3'd5
    } sector_t;

endpackage
`default_nettype wire

// File: rtl/hsv_sector_split.sv
`default_nettype none
// ============================================================================
// Module   : hsv_sector_split
// Purpose  : Splits a wrapped hue (0..359) into 60-degree sector and offset.
// Revision : 1.0 - initial release
// ============================================================================
module hsv_sector_split
#(
    parameter int H_W  = hsv_pkg::H_W,
    parameter int SV_W = hsv_pkg::SV_W
)
(
    input  logic [H_W-1:0]        h,
    output hsv_pkg::sector_t      sector,
    output logic [SV_W-1:0]       f
);
    import hsv_pkg::*;

    logic [H_W-1:0] w_base;

    always_comb begin
        sector = SEC_5;
        w_base = H_W'(5 * HUE_SECTOR);
        if (h < H_W'(HUE_SECTOR)) begin
            sector = SEC_0;
            w_base = '0;
        end else if (h < H_W'(2 * HUE_SECTOR)) begin
            sector = SEC_1;
            w_base = H_W'(HUE_SECTOR);
        end else if (h < H_W'(3 * HUE_SECTOR)) begin
            sector = SEC_2;
            w_base = H_W'(2 * HUE_SECTOR);
        end else if (h < H_W'(4 * HUE_SECTOR)) begin
            sector = SEC_3;
            w_base = H_W'(3 * HUE_SECTOR);
        end else if (h < H_W'(5 * HUE_SECTOR)) begin
            sector = SEC_4;
            w_base = H_W'(4 * HUE_SECTOR);
        end
    end

    assign f = SV_W'(h - w_base);

endmodule
`default_nettype wire

// File: rtl/hsv2rgb565.sv
`default_nettype none
// ============================================================================
// Module   : hsv2rgb565
// Purpose  : 4-stage HSV -> RGB565 converter with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module hsv2rgb565
#(
    parameter int H_W  = hsv_pkg::H_W,
    parameter int SV_W = hsv_pkg::SV_W
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [H_W-1:0]   in_H,
    input  logic [SV_W-1:0]  in_S,
    input  logic [SV_W-1:0]  in_V,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SV_W-2:0]  out_R,
    output logic [SV_W-1:0]  out_G,
    output logic [SV_W-2:0]  out_B
);
    import hsv_pkg::*;

    localparam int PW = 2 * SV_W;
    localparam int XW = PW + 12;

    logic            w_stall;
    logic [H_W-1:0]  w_h;
    logic [SV_W-1:0] w_min, w_c, w_f, w_x;
    sector_t         w_sec;
    logic [XW-1:0]   w_prod;
    logic [SV_W-1:0] w_r, w_g, w_b;

    logic            r_s1_valid, r_s2_valid, r_s3_valid;
    logic [SV_W-1:0] r_s1_max, r_s1_min, r_s1_c, r_s1_f;
    sector_t         r_s1_sec, r_s2_sec, r_s3_sec;
    logic [SV_W-1:0] r_s2_max, r_s2_min;
    logic [PW-1:0]   r_s2_p;
    logic [SV_W-1:0] r_s3_max, r_s3_min, r_s3_rise, r_s3_fall;

    // Whole pipeline freezes on backpressure; no bubble squeezing.
    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall;

    assign w_h   = (in_H >= H_W'(HUE_WRAP)) ? in_H - H_W'(HUE_WRAP) : in_H;
    assign w_min = (in_S > in_V) ? '0 : in_V - in_S;
    assign w_c   = in_V - w_min;

    hsv_sector_split #(.H_W(H_W), .SV_W(SV_W)) u_split (
        .h      (w_h),
        .sector (w_sec),
        .f      (w_f)
    );

    // Reciprocal multiply gives exact floor(P/60) over the reachable P range.
    assign w_prod = XW'(r_s2_p) * XW'(RECIP60);
    assign w_x    = SV_W'(w_prod >> RECIP60_SHIFT);

    always_comb begin
        w_r = r_s3_max;
        w_g = r_s3_min;
        w_b = r_s3_fall;
        case (r_s3_sec)
            SEC_0: begin w_r = r_s3_max;  w_g = r_s3_rise; w_b = r_s3_min;  end
            SEC_1: begin w_r = r_s3_fall; w_g = r_s3_max;  w_b = r_s3_min;  end
            SEC_2: begin w_r = r_s3_min;  w_g = r_s3_max;  w_b = r_s3_rise; end
            SEC_3: begin w_r = r_s3_min;  w_g = r_s3_fall; w_b = r_s3_max;  end
            SEC_4: begin w_r = r_s3_rise; w_g = r_s3_min;  w_b = r_s3_max;  end
            default: begin w_r = r_s3_max; w_g = r_s3_min; w_b = r_s3_fall; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_R      <= '0;
            out_G      <= '0;
            out_B      <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            out_valid  <= r_s3_valid;
            out_R      <= (SV_W-1)'(w_r >> 1);
            out_G      <= w_g;
            out_B      <= (SV_W-1)'(w_b >> 1);
        end
    end

    always_ff @(posedge clock) begin
        if (!w_stall) begin
            r_s1_max  <= in_V;
            r_s1_min  <= w_min;
            r_s1_c    <= w_c;
            r_s1_f    <= w_f;
            r_s1_sec  <= w_sec;

            r_s2_max  <= r_s1_max;
            r_s2_min  <= r_s1_min;
            r_s2_sec  <= r_s1_sec;
            r_s2_p    <= PW'(r_s1_c) * PW'(r_s1_f);

            r_s3_max  <= r_s2_max;
            r_s3_min  <= r_s2_min;
            r_s3_sec  <= r_s2_sec;
            r_s3_rise <= r_s2_min + w_x;
            r_s3_fall <= r_s2_max - w_x;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsv2rgb565.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsv2rgb565
// Purpose  : Self-checking bench for hsv2rgb565 against an arithmetic HSV model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsv2rgb565;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_H;
    logic [5:0] in_S;
    logic [5:0] in_V;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_R;
    logic [5:0] out_G;
    logic [4:0] out_B;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 1'b0;
    logic [15:0] exp_q[$];

    hsv2rgb565 dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_H      (in_H),
        .in_S      (in_S),
        .in_V      (in_V),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_R     (out_R),
        .out_G     (out_G),
        .out_B     (out_B)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: piecewise-linear HSV hexcone with integer floor division.
    function automatic logic [15:0] model(input int h, input int s, input int v);
        int hh, mn, c, sec, f, x, rise, fall, r, g, b;
        hh   = (h >= 360) ? h - 360 : h;
        mn   = (s > v) ? 0 : v - s;
        c    = v - mn;
        sec  = hh / 60;
        f    = hh % 60;
        x    = (c * f) / 60;
        rise = mn + x;
        fall = v - x;
        case (sec)
            0: begin r = v;    g = rise; b = mn;   end
            1: begin r = fall; g = v;    b = mn;   end
            2: begin r = mn;   g = v;    b = rise; end
            3: begin r = mn;   g = fall; b = v;    end
            4: begin r = rise; g = mn;   b = v;    end
            default: begin r = v; g = mn; b = fall; end
        endcase
        return {5'(r / 2), 6'(g), 5'(b / 2)};
    endfunction

    // Scoreboard, handshake rule and stall-freeze checks on every falling edge.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_out;
    always @(negedge clock) begin
        if (mon_en) begin
            if (reset) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
                if (prev_stall) begin
                    chk("stall_valid_hold", int'(out_valid), 1);
                    chk("stall_data_hold", int'({out_R, out_G, out_B}), int'(prev_out));
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(int'(in_H), int'(in_S), int'(in_V)));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        chk("scoreboard_rgb", int'({out_R, out_G, out_B}), int'(exp_q.pop_front()));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_R, out_G, out_B};
            end
        end
    end

    task automatic send(input int h, input int s, input int v);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_H = 9'(h);
        in_S = 6'(s);
        in_V = 6'(v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock) acc = in_ready;
            @(posedge clock) #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Single pixel into an empty pipeline: latency, literal result, one-cycle pulse.
    task automatic directed(input string name, input int h, input int s, input int v,
                            input int er, input int eg, input int eb);
        int n;
        in_valid = 1'b1;
        in_H = 9'(h);
        in_S = 6'(s);
        in_V = 6'(v);
        @(posedge clock) #1;
        in_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clock);
            if (out_valid) break;
            @(posedge clock);
            n++;
        end
        chk({name, "_latency"}, n, 4);
        chk({name, "_R"}, int'(out_R), er);
        chk({name, "_G"}, int'(out_G), eg);
        chk({name, "_B"}, int'(out_B), eb);
        @(posedge clock) #1;
        @(negedge clock);
        chk({name, "_pulse"}, int'(out_valid), 0);
        @(posedge clock) #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock) #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    bit rand_done;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_H = '0; in_S = '0; in_V = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_rgb", int'({out_R, out_G, out_B}), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(posedge clock) #1;
        reset = 1'b0;
        mon_en = 1'b1;

        directed("red",      0,  63, 63, 31,  0,  0);
        directed("orange",   30, 62, 62, 31, 31,  0);
        directed("green",    120, 63, 63, 0, 63,  0);
        directed("gray_h0",  0,   0, 40, 20, 40, 20);
        directed("gray_h77", 77,  0, 40, 20, 40, 20);
        directed("gray_h359", 359, 0, 40, 20, 40, 20);
        directed("s_gt_v",   300, 50, 20, 10,  0, 10);
        directed("wrap400",  400, 63, 63, 31, 42,  0);
        directed("wrap511",  511, 63, 63,  0, 63, 16);
        directed("black",    200, 10,  0,  0,  0,  0);

        // Burst of 8 with a 3-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(int'($urandom_range(0, 511)), int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 63)));
            end
            begin
                repeat (6) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three pixels in flight.
        for (int i = 0; i < 3; i++) send(60 * i + 10, 63, 63);
        reset = 1'b1;
        @(posedge clock) #1;
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_rgb", int'({out_R, out_G, out_B}), 0);
        chk("midreset_in_ready", int'(in_ready), 1);
        @(posedge clock) #1;
        directed("post_reset", 240, 63, 63, 0, 0, 31);

        // Random sweep with random gaps and random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    int s, v;
                    s = int'($urandom_range(0, 63));
                    v = int'($urandom_range(0, 63));
                    if ($urandom_range(0, 15) == 0) s = 0;
                    if ($urandom_range(0, 15) == 0) v = 0;
                    send(int'($urandom_range(0, 511)), s, v);
                    if ($urandom_range(0, 3) == 0) @(posedge clock) #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock) #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
